// File: rtl/bootram_loader_pkg.sv
// Shared types and constants for the serial boot-RAM loader.
package bootram_loader_pkg;

    localparam int BOOT_AW = 8;
    localparam int BOOT_DW = 16;
    localparam int BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADDR,
        S_COUNT,
        S_DLO,
        S_DHI,
        S_WRITE,
        S_CSUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/bootram_loader_csum8.sv
// Modulo-256 running checksum: clear, accumulate, zero-detect of (acc + din).
// Latency: zero is combinational on the current accumulator and din; accumulate lands next clk.
// Backpressure: none; the owner qualifies en/clr with its byte handshake.
module boot_csum8
    import bootram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic              zero
);

    logic [BYTE_W-1:0] acc;
    logic [BYTE_W-1:0] sum;

    assign sum  = acc + din;
    assign zero = (sum == '0);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/bootram_loader.sv
// Framed UART byte stream -> 16-bit boot RAM writes; holds the CPU until the image is in.
// Latency: ram_we one cycle after the high byte; done one cycle after the last write (or CSUM byte).
// Backpressure: rx_ready low during WRITE and DONE; optional checksum under BOOTLOADER_CHECKSUM_EN.
module bootram_loader
    import bootram_loader_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               ram_we,
    output logic [BOOT_AW-1:0] ram_addr,
    output logic [BOOT_DW-1:0] ram_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    state_t              state;
    state_t              state_next;
    logic                xfer;
    logic [BOOT_AW-1:0]  addr_cnt;
    logic [BOOT_AW:0]    word_cnt;
    logic [BYTE_W-1:0]   lo_byte;
    logic [BYTE_W-1:0]   hi_byte;

`ifdef BOOTLOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CSUM;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    assign rx_ready  = (state != S_WRITE) && (state != S_DONE);
    assign xfer      = rx_valid && rx_ready;
    assign ram_we    = (state == S_WRITE);
    assign ram_addr  = addr_cnt;
    assign ram_wdata = {hi_byte, lo_byte};
    assign done      = (state == S_DONE);
    assign cpu_hold  = (state != S_DONE);

`ifdef BOOTLOADER_CHECKSUM_EN
    logic csum_clr;
    logic csum_en;
    logic csum_zero;
    logic error_q;

    assign csum_clr = xfer && (state == S_SYNC) && (rx_data == SYNC_BYTE);
    assign csum_en  = xfer && (state inside {S_ADDR, S_COUNT, S_DLO, S_DHI, S_CSUM});

    boot_csum8 u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (rx_data),
        .zero  (csum_zero)
    );

    always_ff @(posedge clk) begin
        if (reset || csum_clr) begin
            error_q <= 1'b0;
        end else if (xfer && (state == S_CSUM) && !csum_zero) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_SYNC:  if (xfer && (rx_data == SYNC_BYTE)) state_next = S_ADDR;
            S_ADDR:  if (xfer) state_next = S_COUNT;
            S_COUNT: if (xfer) state_next = S_DLO;
            S_DLO:   if (xfer) state_next = S_DHI;
            S_DHI:   if (xfer) state_next = S_WRITE;
            S_WRITE: state_next = (word_cnt == 9'd1) ? S_LAST : S_DLO;
`ifdef BOOTLOADER_CHECKSUM_EN
            S_CSUM:  if (xfer) state_next = csum_zero ? S_DONE : S_SYNC;
`else
            S_CSUM:  state_next = S_SYNC;
`endif
            S_DONE:  state_next = S_DONE;
            default: state_next = S_SYNC;
        endcase
    end

    // A COUNT byte of zero means a full 256-word image, hence the 9-bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= '0;
            word_cnt <= '0;
            lo_byte  <= '0;
            hi_byte  <= '0;
        end else begin
            if (xfer) begin
                case (state)
                    S_ADDR:  addr_cnt <= rx_data;
                    S_COUNT: word_cnt <= {(rx_data == 8'h00), rx_data};
                    S_DLO:   lo_byte  <= rx_data;
                    S_DHI:   hi_byte  <= rx_data;
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                addr_cnt <= addr_cnt + 8'd1;
                word_cnt <= word_cnt - 9'd1;
            end
        end
    end

endmodule

// File: doc/bootram_loader.md
# bootram_loader

Serial boot loader for the 65Org16 system. It accepts a framed byte stream from the UART receiver and assembles 16-bit words. It writes those words into the 256-word boot RAM that the CPU fetches from, and it holds the CPU in reset until a complete, valid image has been written. It is the writing end of the 8-bit-address / 16-bit-data boot memory port that the CPU reads.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid and rx_ready are both high at a rising clk.
- ram_we  output  1  one-cycle write strobe to the boot RAM.
- ram_addr  output  8  boot RAM word address.
- ram_wdata  output  16  boot RAM write data.
- cpu_hold  output  1  drives the CPU reset; high until load completes.
- done  output  1  image loaded; sticky.
- error  output  1  checksum failure; sticky until the next sync byte.

## Operation
- Frame format, in order:
  - SYNC_BYTE
  - ADDR (start word address)
  - COUNT (number of words; 8'h00 means 256)
  - COUNT word pairs, low byte first then high byte
  - CSUM (present only when the macro is defined)
- States: SYNC, ADDR, COUNT, DLO, DHI, WRITE, CSUM, DONE.
- SYNC:
  - A byte equal to SYNC_BYTE clears the accumulator and error, then goes to ADDR.
  - Any other byte is discarded.
- ADDR: latch the byte into the address counter, then go to COUNT.
- COUNT: latch the byte into the 9-bit word counter (8'h00 loads 256), then go to DLO.
- DLO: latch the low byte, then go to DHI.
- DHI: latch the high byte, then go to WRITE.
- WRITE (one cycle, rx_ready low):
  - ram_we=1, ram_addr=address counter, ram_wdata={hi,lo}.
  - The address counter then increments, wrapping 8'hFF to 8'h00.
  - The word counter then decrements.
  - If the word counter reaches 0, go to CSUM, or to DONE when the macro is off. Otherwise go to DLO.
- CSUM: add the byte to the accumulator.
  - Result 8'h00: go to DONE.
  - Nonzero result: set error and go to SYNC. cpu_hold stays high.
- DONE: done=1, cpu_hold=0, rx_ready=0. The loader stays here until reset.
- Accumulator arithmetic: 8-bit, modulo-256 sum of ADDR, COUNT, every data byte and CSUM. SYNC_BYTE is excluded.
- ram_addr and ram_wdata may hold stale values when ram_we=0.

## Timing
- Reset values: rx_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, done=0, error=0; state=SYNC.
- rx_ready is high in SYNC, ADDR, COUNT, DLO, DHI and CSUM. It is low in WRITE and DONE.
- Each state consumes exactly one byte on the handshake. States do not advance without a handshake, and rx_valid gaps of any length are tolerated.
- Write latency: ram_we is high in the cycle immediately after the high byte is accepted.
- Completion latency:
  - Macro on: done rises and cpu_hold falls in the cycle after the CSUM byte is accepted.
  - Macro off: done rises and cpu_hold falls in the cycle after the final ram_we.
- error rises in the cycle after a bad CSUM byte is accepted.
- Reset asserted mid-frame:
  - All outputs return to their reset values on the next clock.
  - Partial words are discarded; words already written remain in the RAM.
- A SYNC_BYTE value arriving mid-frame is treated as data, not as a restart.

## Configuration
- BOOTLOADER_CHECKSUM_EN defined:
  - The CSUM state, accumulator and error flag are present.
  - Frames without a valid checksum never release the CPU.
- BOOTLOADER_CHECKSUM_EN undefined:
  - No CSUM byte is expected.
  - error is tied to 0.
  - DONE follows the last write directly.

## Structure
- Shared package holds:
  - state encoding typedef (SYNC..DONE)
  - SYNC_BYTE default
  - BOOT_AW=8, BOOT_DW=16, byte width 8
- One natural sub-module: boot_csum8, the clear/accumulate/zero-detect checksum unit. It is instantiated only under BOOTLOADER_CHECKSUM_EN.

## Test plan
- Valid frame: stream A5 E0 02 FF FF 9A 00 86.
  - Writes (E0,FFFF) then (E1,009A).
  - done=1 and cpu_hold=0 one cycle after 86 is accepted.
- Bad checksum: same frame with CSUM 87.
  - Both writes occur; error=1; cpu_hold stays 1.
  - Resending a good frame clears error and sets done.
- Address wrap: A5 FF 02 11 22 33 44 plus a correct CSUM.
  - Writes (FF,2211) then (00,4433).
- Count 00:
  - Exactly 256 writes, addresses wrapping from the start address back to it.
  - done after CSUM.
- Backpressure and noise: leading bytes 00 5A before A5, plus random rx_valid gaps between bytes.
  - Noise is ignored; the write sequence matches the valid-frame case.
  - rx_ready is 0 in every WRITE cycle.
- Reset mid-frame: assert reset after DLO of the second word.
  - Next cycle all outputs are at reset values; no second write occurs.
  - A following full frame loads correctly.
